// File: rtl/counter_driver.sv
// Command-side controller for the loadable 3-to-13 up/down counter.
// Accepts jump/walk move requests, steers load/ud/din and reports the outcome.
module counter_driver #(
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_mode,
    input  logic [3:0] req_target,
    input  logic [3:0] count,
    output logic       load,
    output logic       ud,
    output logic [3:0] din,
    output logic       resp_valid,
    output logic       resp_error,
    output logic [3:0] resp_count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        STEP  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          state_reg;
    logic [3:0]      park_reg;
    logic [3:0]      tgt_reg;
    logic [3:0]      exp_reg;
    logic            dir_reg;
    logic [TW-1:0]   tmo_reg;
    logic            load_reg;
    logic [3:0]      din_reg;
    logic            ready_reg;
    logic            resp_valid_reg;
    logic            resp_error_reg;
    logic [3:0]      resp_count_reg;

    logic            hit;
    logic            target_in_range;
    logic            walk_up;
    logic [3:0]      load_exp;

    assign hit             = (count == tgt_reg);
    assign target_in_range = (req_target >= 4'd3) && (req_target <= 4'd13);
    assign walk_up         = (req_target > count);
    // The counter clamps loads below its range to its top value.
    assign load_exp        = (tgt_reg < 4'd3) ? 4'd13 : tgt_reg;

    // While walking, load must react in the same cycle count reaches the target.
    assign load       = (state_reg == STEP) ? hit     : load_reg;
    assign din        = (state_reg == STEP) ? tgt_reg : din_reg;
    assign ud         = dir_reg;
    assign req_ready  = ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_error = resp_error_reg;
    assign resp_count = resp_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            park_reg       <= 4'd13;
            tgt_reg        <= 4'd0;
            exp_reg        <= 4'd0;
            dir_reg        <= 1'b0;
            tmo_reg        <= '0;
            load_reg       <= 1'b1;
            din_reg        <= 4'd13;
            ready_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_error_reg <= 1'b0;
            resp_count_reg <= 4'd0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid && ready_reg) begin
                        tgt_reg   <= req_target;
                        ready_reg <= 1'b0;
                        if (!req_mode) begin
                            state_reg <= LOAD;
                            load_reg  <= 1'b1;
                            din_reg   <= req_target;
                        end else if (target_in_range) begin
                            state_reg <= STEP;
                            dir_reg   <= walk_up;
                            tmo_reg   <= '0;
                        end else begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_error_reg <= 1'b1;
                            resp_count_reg <= count;
                            park_reg       <= count;
                            din_reg        <= count;
                        end
                    end
                end
                LOAD: begin
                    exp_reg   <= load_exp;
                    din_reg   <= load_exp;
                    state_reg <= CHECK;
                end
                CHECK: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_count_reg <= count;
                    resp_error_reg <= (count != exp_reg);
                    if (count != exp_reg) begin
                        park_reg <= count;
                        din_reg  <= count;
                    end else begin
                        park_reg <= exp_reg;
                        din_reg  <= exp_reg;
                    end
                end
                STEP: begin
                    if (hit || (tmo_reg == TMO_LAST)) begin
                        state_reg      <= RESP;
                        dir_reg        <= 1'b0;
                        load_reg       <= 1'b1;
                        resp_valid_reg <= 1'b1;
                        resp_error_reg <= !hit;
                        resp_count_reg <= count;
                        park_reg       <= count;
                        din_reg        <= count;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                RESP: begin
                    state_reg      <= IDLE;
                    ready_reg      <= 1'b1;
                    resp_error_reg <= 1'b0;
                    din_reg        <= park_reg;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    load_reg  <= 1'b1;
                    din_reg   <= park_reg;
                    dir_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule
